// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and constants for the game sequencer
package game_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_HIT     = 2'd2,
    ST_OVER    = 2'd3
  } state_t;
  localparam logic [9:0] LED_ALL_ON = 10'h3FF;
  localparam logic [7:0] BCD_MAX    = 8'h99;
endpackage

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: player/video inputs and display/motion outputs of the game sequencer
interface game_ctrl_if;
  import game_pkg::*;
  logic       flap, bird_color, pipe_color;
  logic       run, new_high;
  state_t     state;
  logic [3:0] score_ones, score_tens, hi_ones, hi_tens;
  logic [9:0] led;
  modport master (
    output flap, bird_color, pipe_color,
    input  run, state, score_ones, score_tens, hi_ones, hi_tens, new_high, led
  );
  modport slave (
    input  flap, bird_color, pipe_color,
    output run, state, score_ones, score_tens, hi_ones, hi_tens, new_high, led
  );
endinterface

// File: rtl/bcd2_counter.sv
// bcd2_counter: two-digit BCD counter with clear, increment enable and saturation at 99
module bcd2_counter
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] ones,
  output logic [3:0] tens
);
  always_ff @(posedge clk)
    if (rst || clr) begin
      ones <= '0;
      tens <= '0;
    end else if (inc && {tens, ones} != BCD_MAX) begin
      ones <= (ones == 4'd9) ? 4'd0 : ones + 4'd1;
      tens <= (ones == 4'd9) ? tens + 4'd1 : tens;
    end
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: Flappy Bird play sequencer, score and LED flash; define HISCORE_EN to keep a high score
module game_ctrl
  import game_pkg::*;
#(
  parameter int TICK_CYCLES    = 75000000,
  parameter int FLASH_CYCLES   = 25000000,
  parameter int HIT_CYCLES     = 50000000,
  parameter int COLLIDE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset_game,
  game_ctrl_if.slave   bus
);
  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int FW = $clog2(FLASH_CYCLES + 1);
  localparam int HW = $clog2(HIT_CYCLES + 1);
  localparam int CW = $clog2(COLLIDE_CYCLES + 1);
  state_t          st;
  logic            flap_q, run_q;
  logic [9:0]      led_q;
  logic [TW-1:0]   tick_cnt;
  logic [FW-1:0]   flash_cnt;
  logic [HW-1:0]   hit_cnt;
  logic [CW-1:0]   col_cnt;
  logic            flap_pulse, overlap, hit_now, tick_wrap, flash_wrap;
  assign flap_pulse = bus.flap & ~flap_q;
  assign overlap    = bus.bird_color & bus.pipe_color;
  assign hit_now    = st == ST_PLAYING && overlap && col_cnt == CW'(COLLIDE_CYCLES - 1);
  assign tick_wrap  = tick_cnt == TW'(TICK_CYCLES - 1);
  assign flash_wrap = flash_cnt == FW'(FLASH_CYCLES - 1);
  // a collision on the wrap cycle suppresses that increment
  bcd2_counter u_score (
    .clk  (clk),
    .rst  (reset_game),
    .clr  (st == ST_IDLE && flap_pulse),
    .inc  (st == ST_PLAYING && tick_wrap && !hit_now),
    .ones (bus.score_ones),
    .tens (bus.score_tens)
  );
  always_ff @(posedge clk)
    if (reset_game) begin
      st        <= ST_IDLE;
      flap_q    <= 1'b0;
      run_q     <= 1'b0;
      led_q     <= '0;
      tick_cnt  <= '0;
      flash_cnt <= '0;
      hit_cnt   <= '0;
      col_cnt   <= '0;
    end else begin
      flap_q <= bus.flap;
      case (st)
        ST_IDLE: if (flap_pulse) begin
          st       <= ST_PLAYING;
          run_q    <= 1'b1;
          tick_cnt <= '0;
          col_cnt  <= '0;
        end
        ST_PLAYING: begin
          col_cnt  <= overlap ? col_cnt + 1'b1 : '0;
          tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
          if (hit_now) begin
            st      <= ST_HIT;
            run_q   <= 1'b0;
            hit_cnt <= '0;
          end
        end
        ST_HIT: begin
          hit_cnt <= hit_cnt + 1'b1;
          if (hit_cnt == HW'(HIT_CYCLES - 1)) begin
            st        <= ST_OVER;
            led_q     <= LED_ALL_ON;
            flash_cnt <= '0;
          end
        end
        default: begin
          flash_cnt <= flash_wrap ? '0 : flash_cnt + 1'b1;
          led_q     <= flap_pulse ? '0 : flash_wrap ? ~led_q : led_q;
          st        <= flap_pulse ? ST_IDLE : ST_OVER;
        end
      endcase
    end
  assign bus.state = st;
  assign bus.run   = run_q;
  assign bus.led   = led_q;
`ifdef HISCORE_EN
  logic [7:0] hi;
  logic       over_q, new_high_q, load;
  // over_q marks the first OVER cycle, where the final score is compared once
  assign load = st == ST_OVER && !over_q && {bus.score_tens, bus.score_ones} > hi;
  always_ff @(posedge clk)
    if (reset_game) begin
      hi         <= '0;
      over_q     <= 1'b0;
      new_high_q <= 1'b0;
    end else begin
      over_q     <= st == ST_OVER;
      new_high_q <= load;
      hi         <= load ? {bus.score_tens, bus.score_ones} : hi;
    end
  assign bus.hi_tens  = hi[7:4];
  assign bus.hi_ones  = hi[3:0];
  assign bus.new_high = new_high_q;
`else
  assign bus.hi_tens  = '0;
  assign bus.hi_ones  = '0;
  assign bus.new_high = 1'b0;
`endif
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: random and directed games checked against an integer-level game model
module tb_game_ctrl;
  import game_pkg::*;
  localparam int T = 10, F = 4, H = 6, C = 2;
  logic clk = 1'b0;
  logic reset_game = 1'b1;
  game_ctrl_if bus ();
  game_ctrl #(
    .TICK_CYCLES    (T),
    .FLASH_CYCLES   (F),
    .HIT_CYCLES     (H),
    .COLLIDE_CYCLES (C)
  ) dut (
    .clk        (clk),
    .reset_game (reset_game),
    .bus        (bus)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [1:0] st;
    logic       run;
    logic [7:0] score;
    logic [7:0] hi;
    logic       nh;
    logic [9:0] led;
  } obs_t;
  obs_t exp_q[$];
  int total = 0, bad = 0;
  int m_st = 0, m_score = 0, m_hi = 0, m_col = 0, m_cyc = 0, m_tin = 0;
  bit m_first = 0, m_nh = 0, m_led = 0, m_flap_q = 0;
  function automatic logic [7:0] to_bcd(int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction
  // model works in decimal score, cycles since game start and cycles in phase
  always @(posedge clk) begin : model
    bit pulse, ov;
    pulse = bus.flap && !m_flap_q;
    m_flap_q = bus.flap;
    ov = bus.bird_color && bus.pipe_color;
    m_nh = 0;
    if (reset_game) begin
      m_st = 0; m_score = 0; m_hi = 0; m_col = 0; m_cyc = 0; m_tin = 0;
      m_first = 0; m_led = 0; m_flap_q = 0;
    end else begin
      case (m_st)
        0: if (pulse) begin m_st = 1; m_score = 0; m_col = 0; m_cyc = 0; end
        1: begin
          m_col = ov ? m_col + 1 : 0;
          m_cyc++;
          if (m_col == C) begin m_st = 2; m_tin = 0; end
          else if (m_cyc % T == 0 && m_score < 99) m_score++;
        end
        2: begin
          m_tin++;
          if (m_tin == H) begin m_st = 3; m_tin = 0; m_first = 1; m_led = 1; end
        end
        default: begin
`ifdef HISCORE_EN
          if (m_first && m_score > m_hi) begin m_hi = m_score; m_nh = 1; end
`endif
          m_first = 0;
          m_tin++;
          m_led = ((m_tin / F) % 2 == 0);
          if (pulse) begin m_st = 0; m_led = 0; end
        end
      endcase
    end
    exp_q.push_back('{2'(m_st), m_st == 1, to_bcd(m_score), to_bcd(m_hi), m_nh,
                      m_led ? 10'h3FF : 10'h000});
  end
  task automatic check(string n, logic [9:0] act, logic [9:0] req);
    total++;
    if (act !== req) begin
      bad++;
      if (bad <= 30) $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, req);
    end
  endtask
  always @(negedge clk) begin : monitor
    obs_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("state", 10'(bus.state), 10'(e.st));
      check("run", 10'(bus.run), 10'(e.run));
      check("score", 10'({bus.score_tens, bus.score_ones}), 10'(e.score));
      check("hi", 10'({bus.hi_tens, bus.hi_ones}), 10'(e.hi));
      check("new_high", 10'(bus.new_high), 10'(e.nh));
      check("led", bus.led, e.led);
    end
  end
  task automatic run(int n, bit ov);
    int r;
    repeat (n) begin
      r = $urandom_range(0, 2);
      bus.bird_color = ov || r == 1;
      bus.pipe_color = ov || r == 2;
      @(negedge clk);
    end
  endtask
  task automatic press(int hold);
    bus.flap = 1'b1;
    run(hold, 0);
    bus.flap = 1'b0;
  endtask
  task automatic pulse_reset;
    reset_game = 1'b1;
    run(1, 0);
    reset_game = 1'b0;
  endtask
  initial begin
    bus.flap = 1'b0;
    bus.bird_color = 1'b0;
    bus.pipe_color = 1'b0;
    repeat (3) @(negedge clk);
    reset_game = 1'b0;
    run(4, 0);
    press(5); run(231, 0); run(2, 1); run(H + 10, 0); press(1); run(3, 0);
    press(1);
    repeat (10) begin run(1, 1); run($urandom_range(1, 3), 0); end
    run(120, 0); run(2, 1); run(H + 9, 0); press(1); run(2, 0);
    press(1); run(78, 0); run(2, 1); run(H + 12, 0); press(1); run(2, 0);
    press(1); run(1270, 0); run(2, 1); run(3, 0); pulse_reset(); run(3, 0);
    press(1); run(25, 0); run(2, 1); run(H + 5, 0); pulse_reset(); run(3, 0);
    repeat (1500) begin
      bus.flap = $urandom_range(0, 7) == 0;
      reset_game = $urandom_range(0, 499) == 0;
      bus.bird_color = $urandom_range(0, 1) == 1;
      bus.pipe_color = $urandom_range(0, 1) == 1;
      @(negedge clk);
    end
    reset_game = 1'b0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
